// File: rtl/fifo2.sv
// Synchronous FIFO whose entries are arrays of ARRAY_SIZE elements, written and read atomically.
// Define FIFO2_BYPASS_EN to forward an entry from in to out in the same cycle when the FIFO is empty.
module fifo2 #(
  parameter int WIDTH      = 64,
  parameter int ARRAY_SIZE = 4,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in [ARRAY_SIZE-1:0],
  input  logic                       in_valid,
  output logic                       in_halt,
  output logic [WIDTH-1:0]           out [ARRAY_SIZE-1:0],
  output logic                       out_valid,
  input  logic                       out_halt,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH][ARRAY_SIZE];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_wr_en;
  logic w_rd_adv;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

`ifdef FIFO2_BYPASS_EN
  assign w_bypass = w_empty & in_valid & ~out_halt;
`else
  assign w_bypass = 1'b0;
`endif

  // Backpressure depends only on registered count, never on out_halt.
  assign in_halt   = w_full;
  assign out_valid = ~w_empty | w_bypass;
  assign count     = r_count;

  assign w_push = in_valid & ~in_halt;
  assign w_pop  = out_valid & ~out_halt;

  // A bypassed entry is handed straight through: no storage, no pointer movement.
  assign w_wr_en  = w_push & ~w_bypass;
  assign w_rd_adv = w_pop & ~w_bypass;

  always_comb begin
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      out[i] = w_bypass ? in[i] : r_mem[r_rd_ptr][i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      unique case ({w_wr_en, w_rd_adv})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
        r_mem[r_wr_ptr][i] <= in[i];
      end
    end
  end

endmodule

// File: tb/tb_fifo2.sv
// Directed self-checking bench for fifo2: a DEPTH=4 instance for the main scenarios and a
// DEPTH=3 instance for pointer wrap at a non-power-of-two depth.
module tb_fifo2;

  localparam int W  = 16;
  localparam int AS = 4;
  localparam int D  = 4;
  localparam int D3 = 3;

`ifdef FIFO2_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk;
  logic         reset;

  logic [W-1:0] din  [AS-1:0];
  logic [W-1:0] dout [AS-1:0];
  logic         in_valid;
  logic         in_halt;
  logic         out_valid;
  logic         out_halt;
  logic [2:0]   count;

  logic [W-1:0] din3  [AS-1:0];
  logic [W-1:0] dout3 [AS-1:0];
  logic         iv3;
  logic         ih3;
  logic         ov3;
  logic         oh3;
  logic [1:0]   count3;

  int n_vec = 0;
  int n_err = 0;

  fifo2 #(.WIDTH(W), .ARRAY_SIZE(AS), .DEPTH(D)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in        (din),
    .in_valid  (in_valid),
    .in_halt   (in_halt),
    .out       (dout),
    .out_valid (out_valid),
    .out_halt  (out_halt),
    .count     (count)
  );

  fifo2 #(.WIDTH(W), .ARRAY_SIZE(AS), .DEPTH(D3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .in        (din3),
    .in_valid  (iv3),
    .in_halt   (ih3),
    .out       (dout3),
    .out_valid (ov3),
    .out_halt  (oh3),
    .count     (count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(input int k, input int i);
    return W'(16'hA000 + k * 16 + i);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k);
    for (int i = 0; i < AS; i++) din[i] = ev(k, i);
  endtask

  task automatic load3(input int k);
    for (int i = 0; i < AS; i++) din3[i] = ev(k, i);
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_halt = 1'b0; iv3 = 1'b0; oh3 = 1'b1;
    load(0); load3(0);
    step;
    step;
    reset = 1'b0;
    #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (in_halt !== 1'b0) begin n_err++; $display("FAIL reset_in_halt got %b want 0", in_halt); end
    n_vec++; if (count3 !== 2'd0) begin n_err++; $display("FAIL reset_count3 got %0d want 0", count3); end
  endtask

  task automatic test_fill_drain;
    out_halt = 1'b1;
    for (int k = 0; k < D; k++) begin
      in_valid = 1'b1; load(k);
      step;
      n_vec++; if (count !== 3'(k + 1)) begin n_err++; $display("FAIL fill_count got %0d want %0d", count, k + 1); end
    end
    in_valid = 1'b0;
    #1;
    n_vec++; if (in_halt !== 1'b1) begin n_err++; $display("FAIL full_in_halt got %b want 1", in_halt); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_out_valid got %b want 1", out_valid); end
    for (int i = 0; i < AS; i++) begin
      n_vec++; if (dout[i] !== ev(0, i)) begin n_err++; $display("FAIL head_A[%0d] got %h want %h", i, dout[i], ev(0, i)); end
    end
    step;
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL hold_count got %0d want 4", count); end
    for (int i = 0; i < AS; i++) begin
      n_vec++; if (dout[i] !== ev(0, i)) begin n_err++; $display("FAIL hold_A[%0d] got %h want %h", i, dout[i], ev(0, i)); end
    end
    out_halt = 1'b0;
    for (int k = 0; k < D; k++) begin
      #1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got %b want 1", k, out_valid); end
      for (int i = 0; i < AS; i++) begin
        n_vec++; if (dout[i] !== ev(k, i)) begin n_err++; $display("FAIL drain_data[%0d][%0d] got %h want %h", k, i, dout[i], ev(k, i)); end
      end
      step;
    end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_full_push_pop;
    out_halt = 1'b1;
    for (int k = 10; k < 14; k++) begin
      in_valid = 1'b1; load(k);
      step;
    end
    load(14); out_halt = 1'b0;
    #1;
    n_vec++; if (in_halt !== 1'b1) begin n_err++; $display("FAIL fpp_halt got %b want 1", in_halt); end
    step;
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL fpp_count1 got %0d want 3", count); end
    n_vec++; if (in_halt !== 1'b0) begin n_err++; $display("FAIL fpp_halt2 got %b want 0", in_halt); end
    n_vec++; if (dout[0] !== ev(11, 0)) begin n_err++; $display("FAIL fpp_head1 got %h want %h", dout[0], ev(11, 0)); end
    step;
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL fpp_count2 got %0d want 3", count); end
    in_valid = 1'b0;
    for (int k = 12; k < 15; k++) begin
      #1;
      for (int i = 0; i < AS; i++) begin
        n_vec++; if (dout[i] !== ev(k, i)) begin n_err++; $display("FAIL fpp_drain[%0d][%0d] got %h want %h", k, i, dout[i], ev(k, i)); end
      end
      step;
    end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL fpp_count_end got %0d want 0", count); end
  endtask

  task automatic test_reset_mid;
    out_halt = 1'b1;
    for (int k = 20; k < 22; k++) begin
      in_valid = 1'b1; load(k);
      step;
    end
    n_vec++; if (count !== 3'd2) begin n_err++; $display("FAIL rmid_pre got %0d want 2", count); end
    reset = 1'b1; in_valid = 1'b1; load(22); out_halt = 1'b0;
    step;
    reset = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL rmid_count got %0d want 0", count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", out_valid); end
    out_halt = 1'b1;
    step;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL rmid_count2 got %0d want 0", count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid2 got %b want 0", out_valid); end
  endtask

  task automatic test_empty_halt;
    in_valid = 1'b0; out_halt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step;
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL empty_count[%0d] got %0d want 0", c, count); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid[%0d] got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_latency;
    out_halt = 1'b0; in_valid = 1'b1; load(30);
    #1;
`ifdef FIFO2_BYPASS_EN
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL byp_valid got %b want 1", out_valid); end
    for (int i = 0; i < AS; i++) begin
      n_vec++; if (dout[i] !== ev(30, i)) begin n_err++; $display("FAIL byp_data[%0d] got %h want %h", i, dout[i], ev(30, i)); end
    end
    step;
    in_valid = 1'b0; out_halt = 1'b1;
    #1;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL byp_count got %0d want 0", count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL byp_after got %b want 0", out_valid); end
`else
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_same_cycle got %b want 0", out_valid); end
    step;
    in_valid = 1'b0; out_halt = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lat_next got %b want 1", out_valid); end
    n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL lat_count got %0d want 1", count); end
    for (int i = 0; i < AS; i++) begin
      n_vec++; if (dout[i] !== ev(30, i)) begin n_err++; $display("FAIL lat_data[%0d] got %h want %h", i, dout[i], ev(30, i)); end
    end
    out_halt = 1'b0;
    step;
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL lat_drain got %0d want 0", count); end
`endif
  endtask

  task automatic test_wrap3;
    logic [39:0] halt_pat;
    int  next_in;
    int  next_out;
    int  m;
    bit  byp;
    bit  exp_ov;
    bit  push_m;
    bit  pop_m;
    halt_pat = 40'b1101_1100_0111_0110_1110_0011_0100_1011_1001_0000;
    next_in = 0; next_out = 0; m = 0;
    for (int cyc = 0; cyc < 60 && next_out < 10; cyc++) begin
      iv3 = (next_in < 10);
      load3(100 + next_in);
      oh3 = halt_pat[cyc % 40];
      #1;
      byp    = BYP && (m == 0) && iv3 && !oh3;
      exp_ov = (m != 0) || byp;
      push_m = iv3 && (m != D3);
      pop_m  = exp_ov && !oh3;
      n_vec++; if (count3 !== 2'(m)) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want %0d", cyc, count3, m); end
      n_vec++; if (ih3 !== (m == D3)) begin n_err++; $display("FAIL wrap_halt[%0d] got %b want %b", cyc, ih3, m == D3); end
      n_vec++; if (ov3 !== exp_ov) begin n_err++; $display("FAIL wrap_valid[%0d] got %b want %b", cyc, ov3, exp_ov); end
      if (pop_m) begin
        for (int i = 0; i < AS; i++) begin
          n_vec++;
          if (dout3[i] !== ev(100 + next_out, i)) begin
            n_err++;
            $display("FAIL wrap_data[%0d][%0d] got %h want %h", next_out, i, dout3[i], ev(100 + next_out, i));
          end
        end
        next_out++;
      end
      if (push_m) next_in++;
      if (!byp) m = m + int'(push_m) - int'(pop_m);
      step;
    end
    iv3 = 1'b0; oh3 = 1'b1;
    n_vec++; if (next_out != 10) begin n_err++; $display("FAIL wrap_done got %0d want 10 entries", next_out); end
    #1;
    n_vec++; if (count3 !== 2'(m)) begin n_err++; $display("FAIL wrap_final_count got %0d want %0d", count3, m); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_halt = 1'b0; iv3 = 1'b0; oh3 = 1'b1;
    for (int i = 0; i < AS; i++) begin
      din[i] = '0; din3[i] = '0;
    end
    test_reset;
    test_fill_drain;
    test_full_push_pop;
    test_reset_mid;
    test_empty_halt;
    test_latency;
    test_wrap3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
